// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory line responder.
// Also read by the dcache controller bench for the default access latency.
package dmem_pkg;

    localparam int LINE_W               = 256;
    localparam int LINE_OFFSET_BITS     = 5;
    localparam int DMEM_DEFAULT_LATENCY = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        INIT = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage: one synchronous write port, one asynchronous read port.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency main-memory model answering one 256-bit line request at a time.
// Optional build macro DMEM_ZERO_INIT_EN adds a post-reset sweep that zeroes every line.
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = DMEM_DEFAULT_LATENCY,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

`ifdef DMEM_ZERO_INIT_EN
    localparam dmem_state_e RESET_STATE = INIT;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
`else
    localparam dmem_state_e RESET_STATE = IDLE;
`endif

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;

    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  req_idx;
    logic [LINE_W-1:0] req_data;
    logic              req_write;
    logic              accept;
    logic              complete;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              unused_addr_bits;

    // Higher line-number bits alias onto the same storage line.
    assign in_idx           = addr_i[LINE_OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^{addr_i[LINE_OFFSET_BITS-1:0], addr_i[ADDR_W-1:LINE_OFFSET_BITS+IDX_W]};

    // With LATENCY==1 acceptance and completion share an edge, so the live inputs are used.
    assign req_idx   = (state_q == IDLE) ? in_idx  : idx_q;
    assign req_data  = (state_q == IDLE) ? data_i  : wdata_q;
    assign req_write = (state_q == IDLE) ? write_i : write_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        complete  = 1'b0;
        ack_o     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        mem_wdata = req_data;
`ifdef DMEM_ZERO_INIT_EN
        init_idx_d = init_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    accept = 1'b1;
                    cnt_d  = CNT_W'(1);
                    if (LATENCY == 1) begin
                        state_d  = ACK;
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ACK;
                    complete = 1'b1;
                end
            end
            ACK: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end
`ifdef DMEM_ZERO_INIT_EN
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_idx_q;
                mem_wdata = '0;
                if (init_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (complete && req_write) begin
            mem_we = 1'b1;
        end
        // A reset edge must never commit a pending write.
        if (rst_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            data_o  <= '0;
`ifdef DMEM_ZERO_INIT_EN
            init_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= in_idx;
                wdata_q <= data_i;
                write_q <= write_i;
            end
            if (complete && !req_write) begin
                data_o <= mem_rdata;
            end
`ifdef DMEM_ZERO_INIT_EN
            init_idx_q <= init_idx_d;
`endif
        end
    end

    dmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (req_idx),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: cycle-exact ack timing, line data via a scoreboard queue.
module tb_dmem_line_responder;
    import dmem_pkg::*;

    localparam int LAT   = DMEM_DEFAULT_LATENCY;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr;
    logic [255:0]  wdata;
    logic          enable;
    logic          write;
    logic          ack;
    logic [255:0]  rdata;

    int            errors = 0;
    int            checks = 0;
    logic [255:0]  exp_q[$];
    logic [255:0]  model [DEPTH];
    logic [255:0]  last_rd;
    logic [255:0]  line_x;
    logic [255:0]  line_y;
    logic [31:0]   wa;
    logic [31:0]   ra;

    always #5 clk = ~clk;

    dmem_line_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .ADDR_W  (32)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (enable),
        .write_i  (write),
        .ack_o    (ack),
        .data_o   (rdata)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_init();
`ifdef DMEM_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk);
            check("init_no_ack", {255'd0, ack}, 256'd0);
        end
`endif
    endtask

    // One request; drop_at/perturb_at/rst_at give the cycle offset after acceptance (0 = never).
    task automatic run_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                           input int drop_at, input int perturb_at, input int rst_at);
        logic [255:0] exp_data;
        @(negedge clk);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        if (!wr) exp_q.push_back(model[a[13:5]]);
        @(posedge clk);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            check("ack_timing", {255'd0, ack}, {255'd0, (rst_at == 0 && k == LAT)});
            if (k == LAT && rst_at == 0 && !wr) begin
                check("sb_nonempty", {255'd0, exp_q.size() != 0}, 256'd1);
                if (exp_q.size() != 0) begin
                    exp_data = exp_q.pop_front();
                    check("read_data", rdata, exp_data);
                    last_rd = exp_data;
                end
            end else begin
                check("data_hold", rdata, last_rd);
            end
            if (k == LAT) enable = 1'b0;
            if (k == drop_at) enable = 1'b0;
            if (k == perturb_at) begin
                addr  = $urandom;
                wdata = rand_line();
                write = ~wr;
            end
            if (k == rst_at) begin
                rst     = 1'b1;
                enable  = 1'b0;
                last_rd = '0;
            end
            if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
        end
        if (wr && rst_at == 0) model[a[13:5]] = d;
        enable = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wdata   = '0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        check("reset_ack", {255'd0, ack}, 256'd0);
        check("reset_data", rdata, 256'd0);
        rst = 1'b0;
        wait_init();
        check("post_reset_ack", {255'd0, ack}, 256'd0);

        run_req(1'b1, 32'h0000_0400, {32{8'hA5}}, 0, 0, 0);
        run_req(1'b0, 32'h0000_0400, '0, 0, 0, 0);
        run_req(1'b0, 32'h0000_041F, '0, 0, 0, 0);

        line_x = rand_line();
        run_req(1'b1, 32'h0000_4400, line_x, 0, 0, 0);
        run_req(1'b0, 32'h0000_0400, '0, 0, 0, 0);

        run_req(1'b1, 32'h0000_0800, 256'h1234, 3, 0, 0);
        run_req(1'b0, 32'h0000_0800, '0, 0, 0, 0);

        line_y = rand_line();
        run_req(1'b1, 32'h0000_0600, line_y, 0, 2, 0);
        run_req(1'b0, 32'h0000_0600, '0, 0, 0, 0);

        run_req(1'b1, 32'h0000_0800, 256'hDEAD, 0, 0, 5);
        wait_init();
        run_req(1'b0, 32'h0000_0800, '0, 0, 0, 0);

        for (int n = 0; n < 4; n++) begin
            wa = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 31));
            ra = ($urandom & 32'hFFFF_C000) | (wa & 32'h0000_3FE0) | 32'($urandom_range(0, 31));
            run_req(1'b1, wa, rand_line(), 0, 0, 0);
            run_req(1'b0, ra, '0, 0, 0, 0);
        end

        check("sb_drained", {224'd0, 32'(exp_q.size())}, 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
